// File: rtl/reg_hazard_scheduler_pkg.sv
// Shared definitions for the register hazard scheduler.
//   REG_NUM    : number of architectural registers tracked by the scoreboard
//   IDX_W      : register index width
//   NO_REG     : index value meaning "no register" (never sets, clears or stalls)
//   fwd_sel_e  : operand source select (regfile, execute resA, execute resB)
//   reg_onehot : decodes an index into a one-hot register vector; NO_REG decodes to zero
package reg_hazard_scheduler_pkg;

    localparam int REG_NUM = 31;
    localparam int IDX_W   = 5;
    localparam logic [IDX_W-1:0] NO_REG = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_RESA = 2'd1,
        FWD_RESB = 2'd2
    } fwd_sel_e;

    // NO_REG lies outside the busy array, so it decodes to an empty vector.
    // That single rule gives index 31 its "ignored everywhere" behaviour.
    function automatic logic [REG_NUM-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
        logic [REG_NUM-1:0] vec;
        vec = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (idx == IDX_W'(i)) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/reg_scoreboard_bank.sv
// Busy-bit array: one pending-write flag per architectural register.
//   clk_i    : core clock
//   rst_i    : asynchronous active-high reset, clears every flag
//   set_i    : registers gaining a new in-flight producer this cycle
//   clr_i    : registers written back this cycle
//   flush_i  : discard all in-flight writes
//   busy_o   : current pending-write flags
module reg_scoreboard_bank
    import reg_hazard_scheduler_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [REG_NUM-1:0] set_i,
    input  logic [REG_NUM-1:0] clr_i,
    input  logic               flush_i,
    output logic [REG_NUM-1:0] busy_o
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_bit
            // Set beats clear: a same-cycle issue is a younger producer than
            // the result being written back, so the register stays pending.
            assign busy_d[gi] = flush_i ? 1'b0
                                        : (set_i[gi] | (busy_q[gi] & ~clr_i[gi]));
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/reg_hazard_scheduler.sv
// Scoreboard / issue scheduler ahead of the execute-stage bypass network.
//   clk_i          : core clock
//   rst_i          : asynchronous active-high reset
//   issue_valid_i  : decode presents an instruction
//   issue_ready_o  : instruction may issue this cycle (combinational, independent of valid)
//   issue_src_i    : sources A/B/C, packed IDX_W each, A in the low bits; 31 = unused
//   issue_dst_i    : destinations resA/resB, packed, resA low; 31 = unused
//   wb_valid_i     : execute results valid this cycle
//   wb_dst_i       : execute resA/resB targets, packed, resA low; 31 = none
//   flush_i        : discard all in-flight writes, block issue
//   fwd_sel_o      : per-source operand select, 2 bits each, source A low
//   busy_mask_o    : pending-write flag per register
//   stall_cnt_o    : saturating count of stalled cycles
//   hang_err_o     : sticky, set once a stall run reaches HANG_LIMIT
module reg_hazard_scheduler
    import reg_hazard_scheduler_pkg::*;
#(
    parameter int HANG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [3*IDX_W-1:0]   issue_src_i,
    input  logic [2*IDX_W-1:0]   issue_dst_i,
    input  logic                 wb_valid_i,
    input  logic [2*IDX_W-1:0]   wb_dst_i,
    input  logic                 flush_i,
    output logic [5:0]           fwd_sel_o,
    output logic [REG_NUM-1:0]   busy_mask_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic                 hang_err_o
);

    localparam int RUN_W = $clog2(HANG_LIMIT + 1);

    logic [IDX_W-1:0]   wb_dst_a;
    logic [IDX_W-1:0]   wb_dst_b;
    logic [REG_NUM-1:0] busy_mask;
    logic [REG_NUM-1:0] wb_clr;
    logic [REG_NUM-1:0] dst_oh [2];
    logic [REG_NUM-1:0] set_vec;
    logic [2:0]         raw_vec;
    logic [1:0]         waw_vec;
    logic               issue_ready;
    logic               fire;
    logic               stall;

    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_d;
    logic [RUN_W-1:0]   run_q;
    logic [RUN_W-1:0]   run_d;
    logic               hang_q;
    logic               hang_d;

    assign wb_dst_a = wb_dst_i[0 +: IDX_W];
    assign wb_dst_b = wb_dst_i[IDX_W +: IDX_W];

    // Registers whose pending write lands this cycle.
    assign wb_clr = wb_valid_i ? (reg_onehot(wb_dst_a) | reg_onehot(wb_dst_b)) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            logic [IDX_W-1:0] src;
            logic             used;
            logic             hit_a;
            logic             hit_b;

            assign src   = issue_src_i[gi*IDX_W +: IDX_W];
            assign used  = (src != NO_REG);
            // Forwarding is decided purely by the execute targets; a hit needs
            // no busy bit, and resA takes precedence when both targets match.
            assign hit_a = used && wb_valid_i && (wb_dst_a == src);
            assign hit_b = used && wb_valid_i && (wb_dst_b == src);
            assign fwd_sel_o[gi*2 +: 2] = hit_a ? FWD_RESA : (hit_b ? FWD_RESB : FWD_RF);
            assign raw_vec[gi] = (|(reg_onehot(src) & busy_mask)) && !(hit_a || hit_b);
        end

        for (gi = 0; gi < 2; gi++) begin : g_dst
            assign dst_oh[gi]  = reg_onehot(issue_dst_i[gi*IDX_W +: IDX_W]);
            // A destination retiring this very cycle no longer blocks a new writer.
            assign waw_vec[gi] = |(dst_oh[gi] & busy_mask & ~wb_clr);
        end
    endgenerate

    assign issue_ready = !flush_i && !(|raw_vec) && !(|waw_vec);
    assign fire        = issue_valid_i && issue_ready;
    assign stall       = issue_valid_i && !issue_ready;
    // OR of both one-hots collapses resA==resB into a single busy bit.
    assign set_vec     = fire ? (dst_oh[0] | dst_oh[1]) : '0;

    reg_scoreboard_bank u_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .set_i   (set_vec),
        .clr_i   (wb_clr),
        .flush_i (flush_i),
        .busy_o  (busy_mask)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        run_d       = run_q;
        hang_d      = hang_q;

        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // The run restarts on any non-stall cycle (fire or idle) and on flush.
        if (!stall || flush_i) begin
            run_d = '0;
        end else begin
            if (run_q == RUN_W'(HANG_LIMIT - 1)) begin
                hang_d = 1'b1;
            end
            if (run_q != RUN_W'(HANG_LIMIT)) begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            run_q       <= '0;
            hang_q      <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            hang_q      <= hang_d;
        end
    end

    assign issue_ready_o = issue_ready;
    assign busy_mask_o   = busy_mask;
    assign stall_cnt_o   = stall_cnt_q;
    assign hang_err_o    = hang_q;

endmodule
